// File: rtl/mult4u_pkg.sv
// Shared types and helpers for the 4-bit multiplier accumulate stage.
package mult4u_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Mod-3 residue of a value up to 8 bits wide (narrower values zero-extended).
    // Even bit positions weigh 1 and odd positions weigh 2 modulo 3.
    function automatic logic [1:0] res3(input logic [PROD_W-1:0] v);
        logic [3:0] s;
        logic [3:0] r;
        s = '0;
        for (int i = 0; i < PROD_W; i++) begin
            if (i % 2 == 1)
                s = s + {2'b00, v[i], 1'b0};
            else
                s = s + {3'b000, v[i]};
        end
        r = s % 4'd3;
        return r[1:0];
    endfunction

endpackage

// File: rtl/mult4u_res3.sv
// Combinational mod-3 residue comparator: flags a product inconsistent with its operands.
module mult4u_res3
    import mult4u_pkg::*;
(
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [PROD_W-1:0] in_p,
    output logic              mismatch
);

    logic [1:0] ra, rb, rp, rprod;
    logic [3:0] prod;

    always_comb begin
        ra       = res3({4'b0000, in_a});
        rb       = res3({4'b0000, in_b});
        rp       = res3(in_p);
        prod     = {2'b00, ra} * {2'b00, rb};
        rprod    = res3({4'b0000, prod});
        mismatch = (rprod != rp);
    end

endmodule

// File: rtl/mult4u_acc_stage.sv
// Accumulates COUNT multiplier products per block and hands the sum out on valid/ready.
// Optional residue checker enabled by defining MULT4U_RESIDUE_CHECK_EN.
module mult4u_acc_stage
    import mult4u_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int COUNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [PROD_W-1:0] in_p,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              out_err
);

    localparam int CNT_W = $clog2(COUNT + 1);

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf, err;

    logic             accept, mism, carry, last;
    logic             nxt_ovf, nxt_err;
    logic [ACC_W-1:0] nxt_acc;
    logic [CNT_W-1:0] nxt_cnt;

`ifdef MULT4U_RESIDUE_CHECK_EN
    mult4u_res3 u_res3 (
        .in_a     (in_a),
        .in_b     (in_b),
        .in_p     (in_p),
        .mismatch (mism)
    );
`else
    logic unused_ops;
    assign unused_ops = ^{in_a, in_b};
    assign mism       = 1'b0;
`endif

    // In HOLD a slot only opens when the held result leaves this same cycle.
    assign in_ready  = !clear && (state == ACCUM || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    assign {carry, nxt_acc} = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_p};
    assign nxt_ovf = ovf | carry;
    assign nxt_err = err | mism;
    assign nxt_cnt = cnt + 1'b1;
    assign last    = (nxt_cnt == CNT_W'(COUNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
            out_err <= 1'b0;
        end else if (clear) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (state == HOLD && out_ready)
                state <= ACCUM;
            if (accept) begin
                if (last) begin
                    // Overrides the consume above when COUNT=1 refills in the same cycle.
                    state   <= HOLD;
                    out_sum <= nxt_acc;
                    out_ovf <= nxt_ovf;
                    out_err <= nxt_err;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                    err     <= 1'b0;
                end else begin
                    acc <= nxt_acc;
                    cnt <= nxt_cnt;
                    ovf <= nxt_ovf;
                    err <= nxt_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult4u_acc_stage.sv
// Bench for mult4u_acc_stage: two configurations driven in parallel against a block-level model.
module tb_mult4u_acc_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, clear = 1'b0, out_ready = 1'b1;
    logic [3:0] in_a = '0, in_b = '0;
    logic [7:0] in_p = '0;

    logic        rdy0, rdy1, v0, v1, ovf0, ovf1, err0, err1;
    logic [11:0] sum0;
    logic [7:0]  sum1;

    mult4u_acc_stage #(.ACC_W(12), .COUNT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_p(in_p), .clear(clear),
        .out_valid(v0), .out_ready(out_ready), .out_sum(sum0),
        .out_ovf(ovf0), .out_err(err0));

    mult4u_acc_stage #(.ACC_W(8), .COUNT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_p(in_p), .clear(clear),
        .out_valid(v1), .out_ready(out_ready), .out_sum(sum1),
        .out_ovf(ovf1), .out_err(err1));

`ifdef MULT4U_RESIDUE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int checks = 0, errors = 0;

    int mw[2] = '{12, 8};
    int mc[2] = '{4, 2};

    int m_tot[2], m_cnt[2], m_sum[2];
    bit m_errf[2], m_valid[2], m_ovf[2], m_err[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bad_res(input int a, input int b, input int p);
        return CHK && (((a * b) % 3) != (p % 3));
    endfunction

    // Block-level model: a block is COUNT accepted products; result is the true sum wrapped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_tot[i] = 0; m_cnt[i] = 0; m_errf[i] = 0;
                m_valid[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit r, take;
                r    = !clear && (!m_valid[i] || out_ready);
                take = in_valid && r;
                if (clear) begin
                    m_tot[i] = 0; m_cnt[i] = 0; m_errf[i] = 0; m_valid[i] = 0;
                end else begin
                    if (m_valid[i] && out_ready) m_valid[i] = 0;
                    if (take) begin
                        m_tot[i]  += int'(in_p);
                        m_errf[i] |= bad_res(int'(in_a), int'(in_b), int'(in_p));
                        m_cnt[i]++;
                        if (m_cnt[i] == mc[i]) begin
                            m_valid[i] = 1;
                            m_sum[i]   = m_tot[i] % (1 << mw[i]);
                            m_ovf[i]   = (m_tot[i] >= (1 << mw[i]));
                            m_err[i]   = m_errf[i];
                            m_tot[i] = 0; m_cnt[i] = 0; m_errf[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int av[2], ar[2], as[2], ao[2], ae[2];
        av = '{int'(v0), int'(v1)};
        ar = '{int'(rdy0), int'(rdy1)};
        as = '{int'(sum0), int'(sum1)};
        ao = '{int'(ovf0), int'(ovf1)};
        ae = '{int'(err0), int'(err1)};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_valid%0d", i), av[i], int'(m_valid[i]));
            chk($sformatf("model_ready%0d", i), ar[i],
                int'(!clear && (!m_valid[i] || out_ready)));
            if (m_valid[i]) begin
                chk($sformatf("model_sum%0d", i), as[i], m_sum[i]);
                chk($sformatf("model_ovf%0d", i), ao[i], int'(m_ovf[i]));
                chk($sformatf("model_err%0d", i), ae[i], int'(m_err[i]));
            end
        end
    end

    task automatic step(input bit v, input int a, input int b, input int p,
                        input bit clr, input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_a      = 4'(a);
        in_b      = 4'(b);
        in_p      = 8'(p);
        clear     = clr;
        out_ready = ordy;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_v0"}, int'(v0), 0);
        chk({nm, "_sum0"}, int'(sum0), 0);
        chk({nm, "_ovf0"}, int'(ovf0), 0);
        chk({nm, "_err0"}, int'(err0), 0);
        chk({nm, "_v1"}, int'(v1), 0);
        chk({nm, "_sum1"}, int'(sum1), 0);
    endtask

    initial begin
        #1;
        chk_zero("reset");
        chk("reset_rdy0", int'(rdy0), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Four products back to back: 15+30+45+225 = 315
        step(1, 3, 5, 15, 0, 1);
        step(1, 5, 6, 30, 0, 1);
        step(1, 5, 9, 45, 0, 1);
        step(1, 15, 15, 225, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("blk1_valid", int'(v0), 1);
        chk("blk1_sum", int'(sum0), 315);
        chk("blk1_ovf", int'(ovf0), 0);
        chk("blk1_err", int'(err0), 0);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("blk1_pulse", int'(v0), 0);

        // Backpressure: result held for 5 cycles, then drained with a same-cycle accept
        repeat (4) step(1, 1, 1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 1, 1, 0, 0);
            @(negedge clk);
            chk("bp_ready", int'(rdy0), 0);
            chk("bp_sum", int'(sum0), 4);
            chk("bp_valid", int'(v0), 1);
        end
        step(1, 1, 2, 2, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("bp_drain_valid", int'(v0), 0);
        step(0, 0, 0, 0, 1, 1);

        // Narrow config wraps: 200+100 = 300 -> 44 with overflow, then 1+2 = 3 clean
        step(1, 1, 2, 200, 0, 1);
        step(1, 1, 1, 100, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("wrap_valid", int'(v1), 1);
        chk("wrap_sum", int'(sum1), 44);
        chk("wrap_ovf", int'(ovf1), 1);
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 2, 2, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("nowrap_sum", int'(sum1), 3);
        chk("nowrap_ovf", int'(ovf1), 0);
        step(0, 0, 0, 0, 1, 1);

        // Clear after two products blocks the concurrent input and restarts the block
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1, 1);
        @(negedge clk);
        chk("clear_ready", int'(rdy0), 0);
        repeat (4) step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("clear_valid", int'(v0), 1);
        chk("clear_sum", int'(sum0), 4);

        // Residue fault 7*5 reported as 36, only for its own block
        step(1, 7, 5, 36, 0, 1);
        repeat (3) step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("res_sum", int'(sum0), 39);
        chk("res_err", int'(err0), int'(CHK));
        repeat (4) step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("res_next_err", int'(err0), 0);
        chk("res_next_sum", int'(sum0), 4);

        // Async reset while holding a result
        repeat (4) step(1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_hold_pre", int'(v0), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_hold");
        @(posedge clk); #1 rst_n = 1'b1;

        // Async reset mid-block, then a fresh block shows no stale state
        step(1, 15, 15, 225, 0, 1);
        step(1, 15, 15, 225, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("post_rst_sum", int'(sum0), 4);
        chk("post_rst_ovf", int'(ovf0), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int a, b, p;
            a = int'($urandom_range(15));
            b = int'($urandom_range(15));
            p = a * b;
            if ($urandom_range(7) == 0) p = int'($urandom_range(255));
            step($urandom_range(3) != 0, a, b, p,
                 $urandom_range(31) == 0, $urandom_range(2) != 0);
        end
        repeat (4) step(0, 0, 0, 0, 0, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
